// File: rtl/stack_pkg.sv
// Shared constants, state encoding and bus-direction codes for the Stack
// command front-end.
package stack_pkg;

  localparam int WIDTH = 8;
  localparam int DEPTH = 1024;
  localparam int LVL_W = 11;

  localparam logic PUSH = 1'b0;
  localparam logic POP  = 1'b1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    PSETUP = 3'd1,
    PWR    = 3'd2,
    PCMD   = 3'd3,
    PCAP   = 3'd4,
    RESP   = 3'd5
  } state_e;

endpackage

// File: rtl/stack_io_drv.sv
// Tri-state driver for the Stack IO bus: registered drive enable and data,
// so the inout is isolated from the controller FSM.
module stack_io_drv
  import stack_pkg::*;
(
  input  logic             Clk,
  input  logic             Reset,
  input  logic             i_drv_set,
  input  logic             i_drv_clr,
  input  logic [WIDTH-1:0] i_data,
  inout  wire  [WIDTH-1:0] io_bus
);

  logic             r_drv_en;
  logic [WIDTH-1:0] r_data;

  // Drive enable and payload update on the same edges as Push_Pop.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_drv_en <= 1'b0;
      r_data   <= {WIDTH{1'b0}};
    end else if (i_drv_set) begin
      r_drv_en <= 1'b1;
      r_data   <= i_data;
    end else if (i_drv_clr) begin
      r_drv_en <= 1'b0;
    end
  end

  assign io_bus = r_drv_en ? r_data : {WIDTH{1'bz}};

endmodule

// File: rtl/stack_bus_ctrl.sv
// Push/pop command front-end for the 1024x8 Stack: sequences Enable, Push_Pop
// and the IO bus with a turnaround cycle, and returns one response per command.
module stack_bus_ctrl
  import stack_pkg::*;
(
  input  logic             Clk,
  input  logic             Reset,
  input  logic             cmd_valid,
  input  logic             cmd_pop,
  input  logic [WIDTH-1:0] cmd_data,
  output logic             cmd_ready,
  output logic             rsp_valid,
  output logic             rsp_err,
  output logic [WIDTH-1:0] rsp_data,
  output logic [LVL_W-1:0] level,
  inout  wire  [WIDTH-1:0] IO,
  output logic             Push_Pop,
  output logic             Enable,
  input  logic             Full,
  input  logic             Empty
);

  state_e           r_state;
  logic             r_cmd_ready;
  logic             r_rsp_valid;
  logic             r_rsp_err;
  logic [WIDTH-1:0] r_rsp_data;
  logic [LVL_W-1:0] r_level;
  logic             r_push_pop;
  logic             r_enable;

  logic             w_accept;
  logic             w_drv_set;
  logic             w_drv_clr;

  assign w_accept  = (r_state == IDLE) && r_cmd_ready && cmd_valid;
  assign w_drv_set = w_accept && (cmd_pop == PUSH) && !Full;
  assign w_drv_clr = (r_state == PWR);

  stack_io_drv u_io_drv (
    .Clk       (Clk),
    .Reset     (Reset),
    .i_drv_set (w_drv_set),
    .i_drv_clr (w_drv_clr),
    .i_data    (cmd_data),
    .io_bus    (IO)
  );

  // Command sequencer, level counter and response registers.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_state     <= IDLE;
      r_cmd_ready <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_data  <= {WIDTH{1'b0}};
      r_level     <= {LVL_W{1'b0}};
      r_push_pop  <= POP;
      r_enable    <= 1'b0;
    end else begin
      r_rsp_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          r_cmd_ready <= 1'b1;
          r_enable    <= 1'b0;
          r_push_pop  <= POP;
          if (w_accept) begin
            r_cmd_ready <= 1'b0;
            if ((cmd_pop == PUSH) && !Full) begin
              r_state    <= PSETUP;
              r_push_pop <= PUSH;
            end else if ((cmd_pop == POP) && !Empty) begin
              r_state  <= PCMD;
              r_enable <= 1'b1;
            end else begin
              // Rejected command: the Stack is never strobed.
              r_state     <= RESP;
              r_rsp_valid <= 1'b1;
              r_rsp_err   <= 1'b1;
              r_rsp_data  <= {WIDTH{1'b0}};
            end
          end
        end
        PSETUP: begin
          r_state  <= PWR;
          r_enable <= 1'b1;
        end
        PWR: begin
          r_state     <= RESP;
          r_enable    <= 1'b0;
          r_push_pop  <= POP;
          r_rsp_valid <= 1'b1;
          r_rsp_err   <= 1'b0;
          r_rsp_data  <= {WIDTH{1'b0}};
          if (r_level != LVL_W'(DEPTH)) r_level <= r_level + 1'b1;
        end
        PCMD: begin
          r_state  <= PCAP;
          r_enable <= 1'b0;
          if (r_level != {LVL_W{1'b0}}) r_level <= r_level - 1'b1;
        end
        PCAP: begin
          r_state     <= RESP;
          r_rsp_valid <= 1'b1;
          r_rsp_err   <= 1'b0;
          r_rsp_data  <= IO;
        end
        RESP: begin
          r_state     <= IDLE;
          r_cmd_ready <= 1'b1;
          r_rsp_err   <= 1'b0;
          r_rsp_data  <= {WIDTH{1'b0}};
        end
        default: begin
          r_state     <= IDLE;
          r_cmd_ready <= 1'b0;
          r_enable    <= 1'b0;
          r_push_pop  <= POP;
        end
      endcase
    end
  end

  assign cmd_ready = r_cmd_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_err   = r_rsp_err;
  assign rsp_data  = r_rsp_data;
  assign level     = r_level;
  assign Push_Pop  = r_push_pop;
  assign Enable    = r_enable;

endmodule

// File: tb/tb_stack_bus_ctrl.sv
// Directed bench for stack_bus_ctrl with a behavioural 1024x8 Stack model.
module tb_stack_bus_ctrl;

  logic       Clk = 1'b0;
  logic       Reset = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_pop = 1'b0;
  logic [7:0] cmd_data = 8'h00;
  logic       cmd_ready;
  logic       rsp_valid;
  logic       rsp_err;
  logic [7:0] rsp_data;
  logic [10:0] level;
  wire  [7:0] IO;
  logic       Push_Pop;
  logic       Enable;
  logic       Full;
  logic       Empty;

  int n_checks = 0;
  int n_fail   = 0;
  int en_cnt   = 0;

  logic [7:0] m_mem [0:1023];
  int         m_cnt = 0;
  logic       m_drv = 1'b0;
  logic [7:0] m_q   = 8'h00;

  stack_bus_ctrl dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .cmd_valid (cmd_valid),
    .cmd_pop   (cmd_pop),
    .cmd_data  (cmd_data),
    .cmd_ready (cmd_ready),
    .rsp_valid (rsp_valid),
    .rsp_err   (rsp_err),
    .rsp_data  (rsp_data),
    .level     (level),
    .IO        (IO),
    .Push_Pop  (Push_Pop),
    .Enable    (Enable),
    .Full      (Full),
    .Empty     (Empty)
  );

  always #5 Clk = ~Clk;

  // Stack model: popped byte is driven for the cycle after the pop while Push_Pop=1.
  assign IO    = (m_drv && Push_Pop) ? m_q : 8'hzz;
  assign Full  = (m_cnt == 1024);
  assign Empty = (m_cnt == 0);

  always @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      m_cnt  <= 0;
      m_drv  <= 1'b0;
      en_cnt <= 0;
    end else begin
      m_drv <= 1'b0;
      if (Enable) en_cnt <= en_cnt + 1;
      if (Enable && !Push_Pop && !Full) begin
        m_mem[m_cnt] <= IO;
        m_cnt <= m_cnt + 1;
      end else if (Enable && Push_Pop && !Empty) begin
        m_q   <= m_mem[m_cnt-1];
        m_cnt <= m_cnt - 1;
        m_drv <= 1'b1;
      end
    end
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Bus contention and level/flag consistency, every cycle out of reset.
  always @(negedge Clk) begin
    if (Reset) begin
      check_val("no_contention", {31'd0, dut.u_io_drv.r_drv_en & Push_Pop}, 32'd0);
      if (cmd_ready) begin
        check_val("lvl_full_iff", {31'd0, level == 11'd1024}, {31'd0, Full});
        check_val("lvl_empty_iff", {31'd0, level == 11'd0}, {31'd0, Empty});
      end
    end
  end

  task automatic do_cmd(input logic pop, input logic [7:0] data, input logic exp_err,
                        input logic [7:0] exp_data, input int exp_lat, input string tag);
    int lat;
    int en0;
    int wc;
    wc = 0;
    while (!cmd_ready && wc < 20) begin
      @(negedge Clk);
      wc++;
    end
    check_val({tag, "_ready"}, {31'd0, cmd_ready}, 32'd1);
    en0 = en_cnt;
    cmd_valid = 1'b1;
    cmd_pop   = pop;
    cmd_data  = data;
    @(posedge Clk);
    @(negedge Clk);
    cmd_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 10) begin
      @(negedge Clk);
      lat++;
    end
    check_val({tag, "_lat"}, lat, exp_lat);
    check_val({tag, "_err"}, {31'd0, rsp_err}, {31'd0, exp_err});
    check_val({tag, "_data"}, {24'd0, rsp_data}, {24'd0, exp_data});
    check_val({tag, "_en_pulses"}, en_cnt - en0, exp_err ? 32'd0 : 32'd1);
    @(negedge Clk);
    check_val({tag, "_rsp_1cyc"}, {31'd0, rsp_valid}, 32'd0);
  endtask

  initial begin
    // Reset with a stray command present.
    Reset = 1'b0;
    cmd_valid = 1'b1;
    repeat (2) @(negedge Clk);
    check_val("rst_ready", {31'd0, cmd_ready}, 32'd0);
    check_val("rst_enable", {31'd0, Enable}, 32'd0);
    check_val("rst_pushpop", {31'd0, Push_Pop}, 32'd1);
    check_val("rst_level", {21'd0, level}, 32'd0);
    check_val("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    cmd_valid = 1'b0;
    Reset = 1'b1;
    @(negedge Clk);
    check_val("idle_ready", {31'd0, cmd_ready}, 32'd1);
    check_val("idle_enable", {31'd0, Enable}, 32'd0);
    check_val("idle_pushpop", {31'd0, Push_Pop}, 32'd1);
    check_val("idle_io_drv", {31'd0, dut.u_io_drv.r_drv_en}, 32'd0);

    do_cmd(1'b1, 8'h00, 1'b1, 8'h00, 1, "pop_empty");
    check_val("pop_empty_level", {21'd0, level}, 32'd0);

    for (int i = 1; i <= 5; i++) begin
      do_cmd(1'b0, 8'(i), 1'b0, 8'h00, 3, "push5");
      check_val("push5_level", {21'd0, level}, i);
    end
    for (int i = 5; i >= 1; i--) begin
      do_cmd(1'b1, 8'h00, 1'b0, 8'(i), 3, "pop5");
      check_val("pop5_level", {21'd0, level}, i - 1);
    end

    for (int i = 0; i < 10; i++) begin
      do_cmd(1'b0, 8'h3C, 1'b0, 8'h00, 3, "alt_push");
      do_cmd(1'b1, 8'h00, 1'b0, 8'h3C, 3, "alt_pop");
    end
    check_val("alt_level", {21'd0, level}, 32'd0);

    for (int i = 0; i < 1024; i++) begin
      do_cmd(1'b0, 8'(i % 256), 1'b0, 8'h00, 3, "fill");
    end
    check_val("fill_full", {31'd0, Full}, 32'd1);
    check_val("fill_level", {21'd0, level}, 32'd1024);
    do_cmd(1'b0, 8'hAA, 1'b1, 8'h00, 1, "push_full");
    check_val("push_full_level", {21'd0, level}, 32'd1024);
    do_cmd(1'b1, 8'h00, 1'b0, 8'hFF, 3, "pop_top");
    check_val("pop_top_level", {21'd0, level}, 32'd1023);

    // Abort a pop in PCMD with an asynchronous reset.
    cmd_valid = 1'b1;
    cmd_pop   = 1'b1;
    @(posedge Clk);
    @(negedge Clk);
    cmd_valid = 1'b0;
    check_val("abort_in_pcmd", {31'd0, Enable}, 32'd1);
    #1 Reset = 1'b0;
    #1;
    check_val("abort_enable", {31'd0, Enable}, 32'd0);
    check_val("abort_pushpop", {31'd0, Push_Pop}, 32'd1);
    check_val("abort_rsp", {31'd0, rsp_valid}, 32'd0);
    repeat (2) begin
      @(negedge Clk);
      check_val("abort_no_rsp", {31'd0, rsp_valid}, 32'd0);
    end
    Reset = 1'b1;
    @(negedge Clk);
    check_val("abort_ready", {31'd0, cmd_ready}, 32'd1);
    check_val("abort_level", {21'd0, level}, 32'd0);
    check_val("abort_rsp_after", {31'd0, rsp_valid}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
